// File: rtl/qysys_pio_out_blink.sv
// qysys_pio_out_blink: Avalon-MM output PIO with atomic set/clear/toggle
// registers and per-bit hardware blinking driven by a programmable prescaler.
// Register map (word address):
//   0 DATA  1 BLINK_EN  2 PERIOD  3 STATUS {running, phase}
//   4 OUTSET  5 OUTCLEAR  6 TOGGLE (write-only, read 0)  7 reserved
`timescale 1ns/1ps
module qysys_pio_out_blink #(
  parameter int unsigned          WIDTH        = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE  = '0,
  parameter int unsigned          PERIOD_W     = 24,
  parameter int unsigned          PERIOD_RESET = 4999999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_W'(PERIOD_RESET);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

  logic [WIDTH-1:0]    data_reg,     data_next;
  logic [WIDTH-1:0]    blink_en_reg, blink_en_next;
  logic [PERIOD_W-1:0] period_reg,   period_next;
  logic [PERIOD_W-1:0] cnt_reg,      cnt_next;
  logic                phase_reg,    phase_next;

  logic                wr_en;
  logic                period_wr;
  logic                running;
  logic [WIDTH-1:0]    wd_w;
  logic [PERIOD_W-1:0] wd_p;

  // Writedata bits above WIDTH / PERIOD_W are deliberately dropped.
  logic                unused_wd;
  assign unused_wd = &{1'b0, writedata};

  assign wr_en     = chipselect & ~write_n;
  assign period_wr = wr_en && (address == ADDR_PERIOD);
  assign running   = |blink_en_reg;
  assign wd_w      = writedata[WIDTH-1:0];
  assign wd_p      = writedata[PERIOD_W-1:0];

  // Register file update: plain writes plus atomic set/clear/toggle of DATA.
  always_comb begin
    data_next     = data_reg;
    blink_en_next = blink_en_reg;
    period_next   = period_reg;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_next     = wd_w;
        ADDR_BLINK_EN: blink_en_next = wd_w;
        ADDR_PERIOD:   period_next   = wd_p;
        ADDR_OUTSET:   data_next     = data_reg | wd_w;
        ADDR_OUTCLEAR: data_next     = data_reg & ~wd_w;
        ADDR_TOGGLE:   data_next     = data_reg ^ wd_w;
        default:       ;
      endcase
    end
  end

  // Prescaler: counts 0..PERIOD while any bit blinks; a PERIOD write restarts
  // the count without disturbing phase, so cnt can never overshoot PERIOD.
  always_comb begin
    cnt_next   = '0;
    phase_next = 1'b0;
    if (running) begin
      phase_next = phase_reg;
      if (period_wr) begin
        cnt_next = '0;
      end else if (cnt_reg == period_reg) begin
        cnt_next   = '0;
        phase_next = ~phase_reg;
      end else begin
        cnt_next = cnt_reg + PERIOD_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg     <= RESET_VALUE;
      blink_en_reg <= '0;
      period_reg   <= PERIOD_INIT;
      cnt_reg      <= '0;
      phase_reg    <= 1'b0;
    end else begin
      data_reg     <= data_next;
      blink_en_reg <= blink_en_next;
      period_reg   <= period_next;
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
    end
  end

  // Each output bit is gated by the blink phase only when it blinks.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
      assign out_port[gi] = data_reg[gi] & (~blink_en_reg[gi] | phase_reg);
    end
  endgenerate

  // Zero-latency read mux; unused upper bits and write-only addresses read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0]    = data_reg;
      ADDR_BLINK_EN: readdata[WIDTH-1:0]    = blink_en_reg;
      ADDR_PERIOD:   readdata[PERIOD_W-1:0] = period_reg;
      ADDR_STATUS:   readdata[1:0]          = {running, phase_reg};
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_qysys_pio_out_blink.sv
// Self-checking bench for qysys_pio_out_blink (WIDTH=8, RESET_VALUE=8'hA5).
// Reference model describes blinking as "edges since restart": the phase is
// the restart phase flipped once per PERIOD+1 elapsed edges.
`timescale 1ns/1ps
module tb_qysys_pio_out_blink;

  localparam logic [7:0]  RV = 8'hA5;
  localparam int unsigned PR = 4999999;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_data;
  logic [7:0]  m_blink;
  logic [23:0] m_period;
  bit          m_base;
  longint      m_k;

  qysys_pio_out_blink #(
    .WIDTH(8), .RESET_VALUE(RV), .PERIOD_W(24), .PERIOD_RESET(PR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  function automatic bit m_phase();
    return m_base ^ bit'((m_k / (longint'(m_period) + 1)) % 2);
  endfunction

  function automatic logic [7:0] m_out();
    bit ph;
    ph = m_phase();
    return m_data & (~m_blink | {8{ph}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {24'd0, m_blink};
      3'd2: return {8'd0, m_period};
      3'd3: return {30'd0, (m_blink != 8'd0), m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_data = RV; m_blink = 8'd0; m_period = 24'(PR); m_base = 1'b0; m_k = 0;
  endtask

  task automatic model_edge(input bit we, input logic [2:0] a, input logic [31:0] d);
    bit ph;
    ph = m_phase();
    if (m_blink != 8'd0) begin
      if (we && a == 3'd2) begin m_base = ph; m_k = 0; end
      else m_k++;
    end else begin
      m_base = 1'b0; m_k = 0;
    end
    if (we) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd1: m_blink = d[7:0];
        3'd2: m_period = d[23:0];
        3'd4: m_data = m_data | d[7:0];
        3'd5: m_data = m_data & ~d[7:0];
        3'd6: m_data = m_data ^ d[7:0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, take the edge (model follows), release 1ns later.
  task automatic step(input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = cs; write_n = wn;
    @(posedge clk);
    model_edge(cs & ~wn, a, d);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
    $display("txn write addr=%0d data=%h out_port=%h", a, d, out_port);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h000000A5; exp_rd[1] = 32'd0; exp_rd[2] = PR; exp_rd[3] = 32'd0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_port !== 8'hA5) begin
      failures++; $display("FAIL reset_out_port got=%h want=%h", out_port, 8'hA5);
    end
    for (int i = 0; i < 4; i++) begin
      address = 3'(i); #1;
      checks++;
      if (readdata !== exp_rd[i]) begin
        failures++; $display("FAIL reset_read addr=%0d got=%h want=%h", i, readdata, exp_rd[i]);
      end
      $display("txn reset read addr=%0d data=%h", i, readdata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle();
  endtask

  task automatic test_data_ops();
    logic [2:0]  addrs [4];
    logic [31:0] datas [4];
    logic [7:0]  exps  [4];
    addrs[0] = 3'd0; datas[0] = 32'hABCDEF0F; exps[0] = 8'h0F;
    addrs[1] = 3'd4; datas[1] = 32'h123456F0; exps[1] = 8'hFF;
    addrs[2] = 3'd5; datas[2] = 32'hFFFF003C; exps[2] = 8'hC3;
    addrs[3] = 3'd6; datas[3] = 32'h000000FF; exps[3] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      wr(addrs[i], datas[i]);
      checks++;
      if (out_port !== exps[i]) begin
        failures++; $display("FAIL data_op_out step=%0d got=%h want=%h", i, out_port, exps[i]);
      end
      address = 3'd0; #1;
      checks++;
      if (readdata !== {24'd0, exps[i]}) begin
        failures++; $display("FAIL data_op_read step=%0d got=%h want=%h", i, readdata, {24'd0, exps[i]});
      end
    end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #1;
      checks++;
      if (readdata !== 32'd0) begin
        failures++; $display("FAIL wo_read addr=%0d got=%h want=0", a, readdata);
      end
    end
    idle();
  endtask

  task automatic test_blink();
    logic [7:0] exp_o;
    wr(3'd2, 32'd3);
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h01);
    for (int j = 0; j < 16; j++) begin
      exp_o = 8'hFE | 8'((j / 4) % 2);
      checks++;
      if (out_port !== exp_o) begin
        failures++; $display("FAIL blink_out cycle=%0d got=%h want=%h", j, out_port, exp_o);
      end
      address = 3'd3; #1;
      checks++;
      if (readdata !== {30'd0, 1'b1, exp_o[0]}) begin
        failures++; $display("FAIL blink_status cycle=%0d got=%h want=%h", j, readdata, {30'd0, 1'b1, exp_o[0]});
      end
      $display("txn blink cycle=%0d out_port=%h status=%h", j, out_port, readdata);
      idle();
    end
  endtask

  task automatic test_blink_off();
    repeat (4) idle();
    checks++;
    if (out_port !== 8'hFF) begin
      failures++; $display("FAIL blink_lit got=%h want=ff", out_port);
    end
    wr(3'd1, 32'd0);
    checks++;
    if (out_port !== 8'hFF) begin
      failures++; $display("FAIL blink_off_out got=%h want=ff", out_port);
    end
    idle();
    address = 3'd3; #1;
    checks++;
    if (readdata !== 32'd0) begin
      failures++; $display("FAIL blink_off_status got=%h want=0", readdata);
    end
    checks++;
    if (out_port !== 8'hFF) begin
      failures++; $display("FAIL blink_off_out2 got=%h want=ff", out_port);
    end
  endtask

  task automatic test_period_change();
    logic [1:0] exp_s [3];
    bit ph;
    exp_s[0] = 2'b10; exp_s[1] = 2'b10; exp_s[2] = 2'b11;
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h01);
    idle(); idle();
    wr(3'd2, 32'd1);
    for (int i = 0; i < 3; i++) begin
      address = 3'd3; #1;
      checks++;
      if (readdata !== {30'd0, exp_s[i]}) begin
        failures++; $display("FAIL period_restart idx=%0d got=%h want=%h", i, readdata, {30'd0, exp_s[i]});
      end
      if (i < 2) idle();
    end
    wr(3'd2, 32'd0);
    ph = 1'b1;
    for (int i = 0; i < 7; i++) begin
      address = 3'd3; #1;
      checks++;
      if (readdata !== {30'd0, 1'b1, ph} || out_port !== (8'hFE | {7'd0, ph})) begin
        failures++; $display("FAIL period_zero idx=%0d status=%h out=%h want_phase=%0d", i, readdata, out_port, ph);
      end
      idle();
      ph = ~ph;
    end
  endtask

  task automatic test_async_reset();
    wr(3'd0, 32'h3C);
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out_port !== RV) begin
      failures++; $display("FAIL async_reset_out got=%h want=%h", out_port, RV);
    end
    address = 3'd1; #1;
    checks++;
    if (readdata !== 32'd0) begin
      failures++; $display("FAIL async_reset_blink got=%h want=0", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    for (int i = 0; i < 10; i++) begin
      address = 3'd3; #1;
      checks++;
      if (readdata !== 32'd0 || out_port !== RV) begin
        failures++; $display("FAIL post_reset idx=%0d status=%h out=%h", i, readdata, out_port);
      end
      idle();
    end
  endtask

  task automatic test_random();
    logic [2:0]  a, ra;
    logic [31:0] d;
    bit          cs, wn;
    for (int i = 0; i < 300; i++) begin
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd2) d[23:0] = 24'($urandom_range(0, 5));
      if (a == 3'd1 && $urandom_range(0, 3) == 0) d[7:0] = 8'd0;
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 1) == 0);
      step(cs, wn, a, d);
      if (cs && !wn) $display("txn rand write addr=%0d data=%h", a, d);
      checks++;
      if (out_port !== m_out()) begin
        failures++; $display("FAIL rand_out iter=%0d got=%h want=%h", i, out_port, m_out());
      end
      ra = 3'($urandom_range(0, 7));
      address = ra; #1;
      checks++;
      if (readdata !== m_read(ra)) begin
        failures++; $display("FAIL rand_read iter=%0d addr=%0d got=%h want=%h", i, ra, readdata, m_read(ra));
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_ops();
    test_blink();
    test_blink_off();
    test_period_change();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qysys_pio_out_blink.md
Name: qysys_pio_out_blink

Overview:
Parametrised successor to the system's fixed 8-bit LED output PIO. It is an Avalon-MM slave that drives WIDTH output bits. It adds atomic set, clear and toggle registers, plus per-bit hardware blinking from a programmable prescaler. It sits on the system interconnect in place of the plain LED PIO, with zero-wait-state reads and writes.

Parameters:
WIDTH, 8, number of output bits (1..32)
RESET_VALUE, 0, value loaded into DATA on reset (WIDTH bits)
PERIOD_W, 24, width of the blink half-period register and counter (1..32)
PERIOD_RESET, 4999999, reset value of PERIOD (half-period = PERIOD+1 clk cycles)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits [WIDTH-1:0] used except PERIOD (bits [PERIOD_W-1:0])
readdata  out  32  read data, combinational from address; unused upper bits 0
out_port  out  WIDTH  LED/output drive

Behaviour:
- One clock: clk. Reset is asynchronous and active-low (reset_n). All state clears on reset assertion, independent of clk.
- Write = chipselect & ~write_n, sampled on the rising edge of clk. The register updates on that edge. No wait states.
- Register map:
  - 0 DATA, R/W. DATA <= wd.
  - 1 BLINK_EN, R/W. Per-bit blink enable.
  - 2 PERIOD, R/W. PERIOD_W bits.
  - 3 STATUS, RO. bit0 = phase, bit1 = counter running.
  - 4 OUTSET, WO. DATA <= DATA | wd.
  - 5 OUTCLEAR, WO. DATA <= DATA & ~wd.
  - 6 TOGGLE, WO. DATA <= DATA ^ wd.
  - 7 reserved; reads 0, writes ignored.
  - Reads of addresses 4, 5, 6 and 7 return 0.
- Read: readdata is a pure function of address and registers, with zero read latency. chipselect is not required for readdata to be valid. Reads have no side effects.
- Reset values:
  - DATA = RESET_VALUE.
  - BLINK_EN = 0.
  - PERIOD = PERIOD_RESET.
  - cnt = 0, phase = 0.
  - out_port = RESET_VALUE.
  - readdata reflects address 0 contents.
- Prescaler:
  - Runs only while BLINK_EN != 0.
  - Each cycle: if cnt == PERIOD then cnt <= 0 and phase <= ~phase; else cnt <= cnt + 1.
  - When BLINK_EN == 0, cnt <= 0 and phase <= 0 on the next edge.
  - A write to PERIOD loads the new value and forces cnt <= 0 on the same edge; phase is unchanged. This guarantees cnt never exceeds PERIOD.
  - PERIOD = 0 toggles phase every cycle.
- Output, combinational from registers: out_port[i] = DATA[i] & (~BLINK_EN[i] | phase).
  - A blinking bit is lit only during phase = 1.
  - A bit with DATA = 0 stays dark regardless of blink.
  - A register write is visible on out_port in the cycle after the write edge.
- Phase timing: starting from cnt = 0, the first phase rise occurs PERIOD+1 cycles after BLINK_EN becomes nonzero. Each subsequent phase lasts exactly PERIOD+1 cycles.
- Simultaneous events: only one register can be written per cycle because of the single address. A PERIOD write while BLINK_EN == 0 leaves cnt at 0.
- Reset mid-blink: out_port returns to RESET_VALUE immediately on reset assertion, and blinking stops until BLINK_EN is rewritten.
- Width rules:
  - writedata bits above WIDTH are ignored for DATA, BLINK_EN, OUTSET, OUTCLEAR and TOGGLE.
  - writedata bits above PERIOD_W are ignored for PERIOD.
  - readdata is zero-extended to 32 bits.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=8'hA5 -> out_port=8'hA5. Read addr 0 = 32'h000000A5, addr 1 = 0, addr 2 = PERIOD_RESET, addr 3 = 0.
- Write DATA=8'h0F, OUTSET 8'hF0, OUTCLEAR 8'h3C, TOGGLE 8'hFF -> DATA reads, in order: 8'h0F, 8'hFF, 8'hC3, 8'h3C. out_port tracks each one cycle after the write. Reads of addrs 4 to 7 return 0.
- PERIOD=3, DATA=8'hFF, BLINK_EN=8'h01 -> out_port[0] is low 4 cycles, then high 4, then low 4, repeating. Bits [7:1] stay 1. STATUS bit1=1.
- While blinking, write BLINK_EN=0 -> within 1 cycle phase=0, cnt=0, and out_port=DATA. STATUS reads 0.
- Mid-blink with cnt=2 and PERIOD=3, write PERIOD=1 -> cnt restarts at 0, and the next phase flip comes 2 cycles after the write. PERIOD=0 -> phase flips every cycle.
- Assert reset_n=0 asynchronously mid-phase, between clk edges -> out_port=RESET_VALUE and BLINK_EN=0 immediately. After release, no toggling occurs until BLINK_EN is written.
